// File: rtl/range_stream_if.sv
// Host and receiver facing signals of range_stream_sender.
// master is the sender side; slave is the host/receiver side.
interface range_stream_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             start;
    logic             busy;
    logic [CW-1:0]    count;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] range_in;
    logic [WIDTH-1:0] range_out;
    logic [WIDTH-1:0] expected_range;
    logic             mismatch;
    logic             done;

    modport master (
        input  load_valid, load_data, start, range_in,
        output load_ready, busy, count, go, finish, data_out,
               range_out, expected_range, mismatch, done
    );

    modport slave (
        output load_valid, load_data, start, range_in,
        input  load_ready, busy, count, go, finish, data_out,
               range_out, expected_range, mismatch, done
    );
endinterface

// File: rtl/range_stream_sender.sv
// Sample FIFO plus go/finish framed sender that checks the receiver's range
// result against its own max-min of the transmitted samples.
module range_stream_sender #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    range_stream_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GO      = 2'd1,
        ST_STREAM  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic             first_q, first_d;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] range_out_q, range_out_d;
    logic [WIDTH-1:0] exp_range_q, exp_range_d;
    logic             mismatch_q, mismatch_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;
    logic             busy_q, busy_d;

    logic             load_acc_s;
    logic             start_acc_s;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] span_s;

    assign head_s      = mem_q[rd_ptr_q];
    assign span_s      = max_q - min_q;
    assign load_acc_s  = (state_q == ST_IDLE) && bus.load_valid && (count_q != CW'(DEPTH));
    // A load accepted on the start edge already counts as part of the frame.
    assign start_acc_s = (state_q == ST_IDLE) && bus.start &&
                         ((count_q != CW'(0)) || load_acc_s);

    // Sample storage; no reset needed since reads are qualified by occupancy.
    always_ff @(posedge clock) begin
        if (load_acc_s) begin
            mem_q[wr_ptr_q] <= bus.load_data;
        end
    end

    // State, FIFO pointers, tracker and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            max_q        <= {WIDTH{1'b0}};
            min_q        <= {WIDTH{1'b0}};
            first_q      <= 1'b0;
            go_q         <= 1'b0;
            finish_q     <= 1'b0;
            data_out_q   <= {WIDTH{1'b0}};
            range_out_q  <= {WIDTH{1'b0}};
            exp_range_q  <= {WIDTH{1'b0}};
            mismatch_q   <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            max_q        <= max_d;
            min_q        <= min_d;
            first_q      <= first_d;
            go_q         <= go_d;
            finish_q     <= finish_d;
            data_out_q   <= data_out_d;
            range_out_q  <= range_out_d;
            exp_range_q  <= exp_range_d;
            mismatch_q   <= mismatch_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, FIFO bookkeeping and max/min tracking
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        max_d       = max_q;
        min_d       = min_q;
        first_d     = first_q;
        range_out_d = range_out_q;
        exp_range_d = exp_range_q;
        mismatch_d  = mismatch_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_acc_s) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                end else begin
                    wr_ptr_d = wr_ptr_q;
                    count_d  = count_q;
                end
                if (start_acc_s) begin
                    state_d = ST_GO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GO: begin
                max_d   = {WIDTH{1'b0}};
                min_d   = {WIDTH{1'b0}};
                first_d = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
                first_d  = 1'b0;
                if (first_q) begin
                    max_d = head_s;
                    min_d = head_s;
                end else begin
                    max_d = (head_s > max_q) ? head_s : max_q;
                    min_d = (head_s < min_q) ? head_s : min_q;
                end
                if (count_q <= CW'(1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_CAPTURE: begin
                range_out_d = bus.range_in;
                exp_range_d = span_s;
                mismatch_d  = (bus.range_in != span_s);
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output images computed from the next state so every output is a flop
    always_comb begin
        go_d         = 1'b0;
        finish_d     = 1'b0;
        data_out_d   = {WIDTH{1'b0}};
        busy_d       = 1'b0;
        load_ready_d = 1'b0;
        if (state_d == ST_GO) begin
            go_d = 1'b1;
        end else begin
            go_d = 1'b0;
        end
        if (state_d == ST_STREAM) begin
            data_out_d = mem_q[rd_ptr_d];
            finish_d   = (count_d == CW'(1));
        end else begin
            data_out_d = {WIDTH{1'b0}};
            finish_d   = 1'b0;
        end
        busy_d       = (state_d != ST_IDLE);
        load_ready_d = (state_d == ST_IDLE) && (count_d != CW'(DEPTH));
    end

    assign bus.go             = go_q;
    assign bus.finish         = finish_q;
    assign bus.data_out       = data_out_q;
    assign bus.count          = count_q;
    assign bus.busy           = busy_q;
    assign bus.load_ready     = load_ready_q;
    assign bus.range_out      = range_out_q;
    assign bus.expected_range = exp_range_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.done           = done_q;
endmodule

// File: doc/range_stream_sender.md
# range_stream_sender

Transmit side of the go/finish sample-stream protocol used by the range finder. A host preloads up to DEPTH samples into an internal FIFO and pulses `start`. The block then emits a framed burst on `go`/`finish`/`data_out`, captures the receiver's `range_in` result, and compares it against its own independently tracked max−min. It sits directly in front of the range finder as its stimulus source and on-chip self-checker.

## Interface
- WIDTH, 16: sample and range width in bits
- DEPTH, 8: FIFO entries; power of 2, ≥2
- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- load_valid  input  1  host offers `load_data` this cycle
- load_data  input  WIDTH  sample to enqueue
- load_ready  output  1  1 when state==IDLE and FIFO not full
- start  input  1  request transmission of all queued samples
- busy  output  1  1 whenever state≠IDLE
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- go  output  1  frame-start strobe to receiver
- finish  output  1  marks last sample of frame
- data_out  output  WIDTH  sample to receiver
- range_in  input  WIDTH  receiver's range result
- range_out  output  WIDTH  captured `range_in`
- expected_range  output  WIDTH  sender-computed max−min of last frame
- mismatch  output  1  range_out ≠ expected_range for last frame
- done  output  1  one-cycle pulse: results updated

## Operation
- FSM states: IDLE, GO, STREAM, CAPTURE. `go`=(state==GO); `finish`=(state==STREAM && count==1).
- IDLE: a load is accepted when load_valid && load_ready, and it pushes to the FIFO.
  - A start is accepted when start && (count≥1 or a load is accepted the same cycle); the FSM then moves to GO. A load accepted in the same cycle is part of the frame.
  - start with an empty FIFO and no load is ignored.
- GO: data_out=0; clear tracker; go to STREAM.
- STREAM: data_out=FIFO head; pop every cycle.
  - First sample sets max=min=sample. Later samples update max/min unsigned.
  - On the pop where count==1, finish=1; next state is CAPTURE.
- CAPTURE: range_out<=range_in, expected_range<=max−min (unsigned, WIDTH bits), mismatch<=(range_in≠max−min). Next state is IDLE.
- done is a registered pulse, high exactly the cycle after CAPTURE, concurrent with the new range_out, expected_range and mismatch.
- start, load_valid are ignored while busy. No loads are accepted during a frame.
- FIFO full: load_ready=0; load_valid is dropped with no side effect.
- FIFO pointers wrap modulo DEPTH. Occupancy saturates conceptually at DEPTH; count never exceeds DEPTH.
- range_out, expected_range and mismatch hold until the next CAPTURE.

## Timing
- Reset (async assert, sync release): state=IDLE, FIFO empty, count=0, go=0, finish=0, data_out=0, range_out=0, expected_range=0, mismatch=0, done=0. go/finish fall immediately on reset assertion.
- Reset mid-frame: frame abandoned, FIFO flushed, no done pulse.
- Start sampled at edge k with N samples queued:
  - go high cycle k+1.
  - Samples on data_out cycles k+2 … k+1+N.
  - finish high cycle k+1+N together with the last sample.
  - CAPTURE cycle k+2+N (receiver result valid).
  - done and new results at cycle k+3+N.
- Frame length in cycles = N+3 from start to done. load_ready returns to 1 at cycle k+3+N.
- N=1: go in k+1, sample plus finish in k+2, done in k+4.
- No back-pressure from the receiver; the stream is continuous with no gaps.

## Test plan
- Load 5,9,2,7 then start → go, then data 5,9,2,7 with finish on 7, expected_range=7. Receiver returns 7 → mismatch=0; done 7 cycles after start.
- Single sample 0x1234, start → one data cycle with finish, expected_range=0, done at k+4.
- Load DEPTH=8 values; a 9th load_valid → load_ready=0, sample dropped, count stays 8. The frame sends exactly 8 samples.
- Drive range_in=3 while expected_range=10 → mismatch=1, range_out=3. A following correct frame clears mismatch.
- Start with empty FIFO → no go, busy stays 0. Start plus load_valid(0xFFFF) in the same cycle with empty FIFO → 1-sample frame of 0xFFFF.
- Deassert reset_n during STREAM → go/finish/data_out drop to 0 immediately, count=0, no done. A new load/start then runs normally.
